row_clear_ctrl: RTL and testbench
=================================

Name: row_clear_ctrl

Overview:
Sequencer for line clearing. The game FSM pulses start once a piece locks. The block then scans the captured board from bottom to top. Each complete row is removed by shifting every row above it down one position, and rows are counted as they are cleared. When finished it returns the compacted board and the cleared-line count with a one-cycle done pulse, which feeds the score and level logic.

Parameters:
BLOCKS_WIDE, 10, cells per row
BLOCKS_HIGH, 22, rows on the board
BITS_Y_POS, 5, row index width; must satisfy 2^BITS_Y_POS > BLOCKS_HIGH

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
pause  in  1  high freezes the FSM in SCAN/SHIFT; state, row and board hold
start  in  1  request a clear pass; sampled only in IDLE
board_in  in  BLOCKS_WIDE*BLOCKS_HIGH  fallen pieces; row r occupies bits r*BLOCKS_WIDE +: BLOCKS_WIDE; row 0 is the top row
board_out  out  BLOCKS_WIDE*BLOCKS_HIGH  working/compacted board; valid while done is high and held until the next accepted start
lines_cleared  out  BITS_Y_POS  rows removed in the last pass; valid with done
scan_row  out  BITS_Y_POS  row currently under test
busy  out  1  high whenever state != IDLE
done  out  1  single-cycle pulse at the end of a pass

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, board_out=0, lines_cleared=0, scan_row=0, busy=0, done=0.
- IDLE:
  - start=1 at an edge → capture board_in into board_out, scan_row=BLOCKS_HIGH-1, lines_cleared=0, go to SCAN.
  - start while busy is ignored; it is neither queued nor counted.
- SCAN (one row evaluated per edge): full = AND of all bits of board_out row scan_row.
  - full=1 → go to SHIFT; scan_row unchanged.
  - full=0 and scan_row=0 → go to DONE.
  - full=0 otherwise → scan_row decrements by 1.
- SHIFT (one cycle):
  - For r = scan_row down to 1: row r takes the old row r-1.
  - Row 0 becomes all zeros.
  - Rows below scan_row are untouched.
  - lines_cleared increments by 1.
  - Return to SCAN at the same scan_row, so the row that dropped in is re-tested.
- DONE: done=1 for exactly one cycle, then go to IDLE. board_out and lines_cleared hold until the next accepted start.
- Latency: with the start edge as cycle 0, done is high in cycle BLOCKS_HIGH + 2*N, where N is the number of rows cleared (each clear adds a SHIFT cycle and a re-test cycle).
- Full top row (row 0): the clear zeroes row 0, the re-test fails, and the FSM goes to DONE.
- lines_cleared never exceeds BLOCKS_HIGH and does not wrap at the parameter minimum width.
- pause=1 in SCAN or SHIFT: no state, row, board or count change. Pause has no effect in IDLE or DONE; done still pulses for one cycle only.
- board_in changing during a pass has no effect; only the copy captured at start is used.
- rst_n low mid-pass: immediate return to the reset values. The partially cleared board is discarded.

Test Plan:
- Empty board, start pulse → done in cycle 22, lines_cleared=0, board_out=0, busy high in cycles 1..22.
- Row 21 full, row 20 = 10'h155, rest 0 → done in cycle 24, lines_cleared=1, row 21=10'h155, all other rows 0.
- Rows 21,20,19,18 full, row 17=10'h001 → lines_cleared=4, done in cycle 30, row 21=10'h001, rows 0..20 zero.
- Non-adjacent rows 21 and 19 full, rows 20=10'h003 and 18=10'h300 → lines_cleared=2, row 21=10'h003, row 20=10'h300, rest 0.
- Row 0 full only, with pause held high for 5 cycles mid-scan → lines_cleared=1, board all zero, done in cycle 29 (22+2+5), scan_row frozen during pause.
- rst_n low while in SHIFT, then start with an empty board → outputs at reset values immediately; the second pass completes normally with lines_cleared=0; start pulses while busy produce no extra done.

Source files
------------

// File: rtl/row_clear_ctrl.sv
// Line-clear sequencer: scans a captured board bottom-up, removes full rows by
// shifting the rows above down one place, and counts the rows removed.
module row_clear_ctrl #(
  parameter int BLOCKS_WIDE = 10,
  parameter int BLOCKS_HIGH = 22,
  parameter int BITS_Y_POS  = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pause,
  input  logic                               start,
  input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_in,
  output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
  output logic [BITS_Y_POS-1:0]              lines_cleared,
  output logic [BITS_Y_POS-1:0]              scan_row,
  output logic                               busy,
  output logic                               done
);

  localparam int BW = BLOCKS_WIDE * BLOCKS_HIGH;
  localparam logic [BITS_Y_POS-1:0] LAST_ROW  = BITS_Y_POS'(BLOCKS_HIGH - 1);
  localparam logic [BITS_Y_POS-1:0] ROW_COUNT = BITS_Y_POS'(BLOCKS_HIGH);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [BW-1:0]           board_reg, board_next;
  logic [BW-1:0]           shifted_board;
  logic [BITS_Y_POS-1:0]   row_reg, row_next;
  logic [BITS_Y_POS-1:0]   lines_reg, lines_next;
  logic [BLOCKS_HIGH-1:0]  row_full;
  logic                    cur_full;

  // Per-row fullness flags and the "remove row_reg" image of the board.
  // Rows at or above row_reg take the row one higher; row 0 is refilled empty.
  generate
    for (genvar gi = 0; gi < BLOCKS_HIGH; gi++) begin : g_rows
      assign row_full[gi] = &board_reg[gi*BLOCKS_WIDE +: BLOCKS_WIDE];
      if (gi == 0) begin : g_top
        assign shifted_board[0 +: BLOCKS_WIDE] = '0;
      end else begin : g_lower
        assign shifted_board[gi*BLOCKS_WIDE +: BLOCKS_WIDE] =
          (BITS_Y_POS'(gi) <= row_reg) ? board_reg[(gi-1)*BLOCKS_WIDE +: BLOCKS_WIDE]
                                       : board_reg[gi*BLOCKS_WIDE +: BLOCKS_WIDE];
      end
    end
  endgenerate

  assign cur_full = (row_reg <= LAST_ROW) && row_full[row_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      board_reg <= '0;
      row_reg   <= '0;
      lines_reg <= '0;
    end else begin
      state_reg <= state_next;
      board_reg <= board_next;
      row_reg   <= row_next;
      lines_reg <= lines_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    board_next = board_reg;
    row_next   = row_reg;
    lines_next = lines_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          board_next = board_in;
          row_next   = LAST_ROW;
          lines_next = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (!pause) begin
          if (cur_full) begin
            state_next = SHIFT;
          end else if (row_reg == '0) begin
            state_next = DONE;
          end else begin
            row_next = row_reg - 1'b1;
          end
        end
      end
      SHIFT: begin
        if (!pause) begin
          board_next = shifted_board;
          // A pass can never clear more rows than the board holds.
          if (lines_reg < ROW_COUNT) begin
            lines_next = lines_reg + 1'b1;
          end
          state_next = SCAN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign board_out     = board_reg;
  assign lines_cleared = lines_reg;
  assign scan_row      = row_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Bench for row_clear_ctrl: directed boards plus random passes checked against
// a row-list model of line clearing and the stated pass latency.
module tb_row_clear_ctrl;

  localparam int W  = 10;
  localparam int H  = 22;
  localparam int YB = 5;
  localparam int BW = W * H;

  logic          clk;
  logic          rst_n;
  logic          pause;
  logic          start;
  logic [BW-1:0] board_in;
  logic [BW-1:0] board_out;
  logic [YB-1:0] lines_cleared;
  logic [YB-1:0] scan_row;
  logic          busy;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  row_clear_ctrl #(
    .BLOCKS_WIDE (W),
    .BLOCKS_HIGH (H),
    .BITS_Y_POS  (YB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pause         (pause),
    .start         (start),
    .board_in      (board_in),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .scan_row      (scan_row),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep the non-full rows in bottom-to-top order, pack them at the
  // bottom, fill the rest with empty rows.
  function automatic void model(input logic [BW-1:0] b, output logic [BW-1:0] res, output int n);
    logic [W-1:0] row;
    int dst;
    res = '0;
    n   = 0;
    dst = H - 1;
    for (int r = H - 1; r >= 0; r--) begin
      row = b[r*W +: W];
      if (&row) begin
        n++;
      end else begin
        res[dst*W +: W] = row;
        dst--;
      end
    end
  endfunction

  function automatic logic [BW-1:0] set_row(input logic [BW-1:0] b, input int r, input logic [W-1:0] v);
    logic [BW-1:0] t;
    t = b;
    t[r*W +: W] = v;
    return t;
  endfunction

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] t;
    logic [W-1:0]  full_row;
    full_row = '1;
    t = '0;
    for (int r = 0; r < H; r++) begin
      case ($urandom_range(0, 2))
        0:       t[r*W +: W] = full_row;
        1:       t[r*W +: W] = W'($urandom);
        default: t[r*W +: W] = '0;
      endcase
    end
    return t;
  endfunction

  // One pass: start at edge 0, optional pause on edges pfrom..pfrom+plen-1,
  // optional noise (start pulses and board_in churn) while busy.
  task automatic run_pass(input string tag, input logic [BW-1:0] b,
                          input int pfrom, input int plen, input bit noise);
    logic [BW-1:0] exp_b;
    logic [YB-1:0] prev_row;
    int            exp_n, exp_l, found;
    bit            busy_ok, frz_ok, paused_edge, extra_done;
    model(b, exp_b, exp_n);
    exp_l = H + 2 * exp_n + plen;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    pause    = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_row_init"}, BW'(scan_row), BW'(H - 1));
    found    = 0;
    busy_ok  = 1'b1;
    frz_ok   = 1'b1;
    prev_row = scan_row;
    pause    = (1 >= pfrom) && (1 < pfrom + plen);
    for (int cyc = 1; cyc <= 300 && found == 0; cyc++) begin
      paused_edge = pause;
      @(posedge clk);
      #1;
      if (paused_edge && scan_row !== prev_row) frz_ok = 1'b0;
      prev_row = scan_row;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) found = cyc;
      pause = (cyc + 1 >= pfrom) && (cyc + 1 < pfrom + plen);
      if (noise && found == 0) begin
        start    = (cyc < exp_l) ? 1'($urandom_range(0, 1)) : 1'b0;
        board_in = rand_board();
      end
    end
    start = 1'b0;
    pause = 1'b0;
    chk({tag, "_done_cycle"}, BW'(found), BW'(exp_l));
    chk({tag, "_busy_during"}, BW'(busy_ok), BW'(1));
    if (plen > 0) chk({tag, "_row_frozen"}, BW'(frz_ok), BW'(1));
    chk({tag, "_board"}, board_out, exp_b);
    chk({tag, "_lines"}, BW'(lines_cleared), BW'(exp_n));
    @(posedge clk);
    #1;
    chk({tag, "_done_single"}, BW'(done), BW'(0));
    chk({tag, "_idle_busy"}, BW'(busy), BW'(0));
    chk({tag, "_board_hold"}, board_out, exp_b);
    chk({tag, "_lines_hold"}, BW'(lines_cleared), BW'(exp_n));
    extra_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) extra_done = 1'b1;
    end
    chk({tag, "_no_extra_done"}, BW'(extra_done), BW'(0));
  endtask

  logic [BW-1:0] b;
  logic [W-1:0]  full_row;

  initial begin
    full_row = '1;
    rst_n    = 1'b0;
    pause    = 1'b0;
    start    = 1'b0;
    board_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_board", board_out, '0);
    chk("rst_lines", BW'(lines_cleared), BW'(0));
    chk("rst_row", BW'(scan_row), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_done", BW'(done), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_pass("empty", '0, 0, 0, 1'b0);

    b = set_row('0, 21, full_row);
    b = set_row(b, 20, 10'h155);
    run_pass("one_row", b, 0, 0, 1'b0);

    b = set_row('0, 21, full_row);
    b = set_row(b, 20, full_row);
    b = set_row(b, 19, full_row);
    b = set_row(b, 18, full_row);
    b = set_row(b, 17, 10'h001);
    run_pass("four_rows", b, 0, 0, 1'b0);

    b = set_row('0, 21, full_row);
    b = set_row(b, 19, full_row);
    b = set_row(b, 20, 10'h003);
    b = set_row(b, 18, 10'h300);
    run_pass("split_rows", b, 0, 0, 1'b0);

    b = set_row('0, 0, full_row);
    run_pass("top_row_pause", b, 5, 5, 1'b0);

    b = '1;
    run_pass("all_full", b, 0, 0, 1'b0);

    // Reset asserted while the first full row is being shifted out.
    @(negedge clk);
    board_in = set_row('0, 21, full_row);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_busy", BW'(busy), BW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_board", board_out, '0);
    chk("mid_rst_lines", BW'(lines_cleared), BW'(0));
    chk("mid_rst_row", BW'(scan_row), BW'(0));
    chk("mid_rst_busy", BW'(busy), BW'(0));
    chk("mid_rst_done", BW'(done), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_pass("after_rst", '0, 0, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        run_pass("rand_pause", rand_board(), int'($urandom_range(1, 10)), int'($urandom_range(1, 8)), 1'b1);
      else
        run_pass("rand", rand_board(), 0, 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
